sdes_cipher_core: RTL
=====================

// Module: sdes_cipher_core
// PURPOSE
//  Sequential S-DES block engine. Applies the forward initial permutation IP, two
//  Feistel rounds with 8-bit subkeys K1/K2 derived from a 10-bit key, then IP^-1.
//  Sits between the byte source and sink of the S-DES datapath.
//  One block in flight at a time, with a start/busy/done handshake.
// PARAMETERS
//  TEXT_W  8   block width; localparam, fixed
//  KEY_W   10  key width; localparam, fixed
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  start       in   1   request; sampled only in IDLE
//  keyIn       in   [0:9]  cipher key; bit 1 of the S-DES notation = index 0
//  inputText   in   [0:7]  plaintext (or ciphertext when decrypting)
//  outputText  out  [0:7]  result; registered; holds until the next completion
//  busy        out  1   high from the cycle after acceptance to the end of FIN
//  done        out  1   one-cycle pulse when outputText updates
// BEHAVIOUR
//  Reset: state=IDLE, outputText=8'h00, busy=0, done=0, internal registers=0.
//    Reset is asynchronous and may arrive at any time. A block in progress is
//    aborted and no done is generated.
//  FSM: IDLE -> PERM -> RND1 -> RND2 -> FIN -> IDLE. Each state lasts 1 cycle.
//  Edge N (IDLE, start=1): latch keyIn and inputText; go to PERM.
//    keyIn and inputText changes after edge N are ignored.
//  Edge N+1 (PERM): reg <= IP(text), with IP=(2,6,3,1,4,8,5,7).
//    Also compute P10=(3,5,2,7,4,10,1,9,8,6) and split into 5-bit halves.
//    K1 = P8(LS1 of each half); K2 = P8(LS3 of each half).
//    P8=(6,3,7,4,8,5,10,9).
//  Edge N+2 (RND1): {L,R} <= {R, L ^ F(R,Ka)}. Halves are swapped.
//  Edge N+3 (RND2): {L,R} <= {L ^ F(R,Kb), R}. No swap.
//  Edge N+4 (FIN): outputText <= IP^-1(reg), with IP^-1=(4,1,3,5,7,2,8,6).
//    done <= 1 for exactly one cycle. busy <= 0. Return to IDLE.
//  F(R,K): E/P=(4,1,2,3,2,3,4,1); x = EP(R) ^ K.
//    S0 takes x[1:4], S1 takes x[5:8].
//    Row = bits(1,4), column = bits(2,3) of each nibble.
//    S0 = {1,0,3,2 | 3,2,1,0 | 0,2,1,3 | 3,1,3,2}
//    S1 = {0,1,2,3 | 2,0,1,3 | 3,0,1,0 | 2,1,0,3}
//    Result = P4(S0out,S1out) with P4=(2,4,3,1).
//  Latency: 4 clocks from the start sample to the outputText/done update.
//    Throughput: one block per 5 cycles.
//    A start during the done cycle is accepted, since the FSM is already in IDLE.
//  start while busy: ignored. It is not queued. No error flag.
//  start held high continuously: back-to-back blocks, each re-latching the inputs.
//  Subkey order: Ka=K1, Kb=K2 for encryption.
// CONFIGURATION
//  SDES_DECRYPT_EN defined: adds input port `decrypt` (1 bit), latched at edge N.
//    decrypt=1 selects Ka=K2, Kb=K1; the same datapath then performs decryption.
//  SDES_DECRYPT_EN undefined: port is absent; encryption only (Ka=K1, Kb=K2).
// TESTING
//  T1 reset: assert reset mid-RND1 -> busy=0, done=0, outputText=00 at once.
//    No done follows after release.
//  T2 vector: key=1010000010, text=10010111, start 1 cycle -> K1=10100100,
//    K2=01000011, outputText=00111000, done exactly 4 clocks after start.
//  T3 busy: start=1 again during PERM/RND1/RND2 with other data -> ignored.
//    Only one done pulse; result = 00111000.
//  T4 back-to-back: start held high for 2 blocks -> done pulses 5 cycles apart.
//    Each result matches the golden S-DES model.
//  T5 (SDES_DECRYPT_EN): decrypt=1, key=1010000010, text=00111000 ->
//    outputText=10010111.
//  T6 random: 1000 random key/text pairs vs reference model.
//    encrypt->decrypt round trip = identity, when DECRYPT_EN is compiled in.

Source files
------------

// File: rtl/sdes_cipher_core.sv
// -----------------------------------------------------------------------------
// sdes_cipher_core
//   Sequential S-DES block engine. One 8-bit block is processed at a time:
//   IP, two Feistel rounds keyed by subkeys derived from a 10-bit key, then
//   IP^-1. The FSM walks IDLE -> PERM -> RND1 -> RND2 -> FIN -> IDLE, so the
//   result appears 4 clocks after start is sampled.
//
//   Bit numbering follows the S-DES notation: bit 1 of a value is index 0 of
//   the ascending-range vectors below.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous active-high reset
//   start       in   1      block request, sampled only in IDLE
//   decrypt     in   1      (only with SDES_DECRYPT_EN) swap subkey order
//   keyIn       in   [0:9]  cipher key
//   inputText   in   [0:7]  plaintext / ciphertext
//   outputText  out  [0:7]  registered result, held until next completion
//   busy        out  1      high from PERM through FIN
//   done        out  1      one-cycle pulse when outputText updates
//
// Configuration
//   SDES_DECRYPT_EN : when defined, adds the decrypt input (latched with the
//                     block). Undefined: encryption only.
// -----------------------------------------------------------------------------
module sdes_cipher_core (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef SDES_DECRYPT_EN
    input  logic       decrypt,
`endif
    input  logic [0:9] keyIn,
    input  logic [0:7] inputText,
    output logic [0:7] outputText,
    output logic       busy,
    output logic       done
);

    localparam int TEXT_W = 8;
    localparam int KEY_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PERM = 3'd1,
        ST_RND1 = 3'd2,
        ST_RND2 = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // ---------------------------------------------------------------------
    // Permutation and round helpers (indices are S-DES positions minus one)
    // ---------------------------------------------------------------------
    function automatic logic [0:7] perm_ip(input logic [0:7] t);
        perm_ip = {t[1], t[5], t[2], t[0], t[3], t[7], t[4], t[6]};
    endfunction

    function automatic logic [0:7] perm_ip_inv(input logic [0:7] t);
        perm_ip_inv = {t[3], t[0], t[2], t[4], t[6], t[1], t[7], t[5]};
    endfunction

    function automatic logic [0:9] perm_p10(input logic [0:9] k);
        perm_p10 = {k[2], k[4], k[1], k[6], k[3], k[9], k[0], k[8], k[7], k[5]};
    endfunction

    function automatic logic [0:7] perm_p8(input logic [0:9] k);
        perm_p8 = {k[5], k[2], k[6], k[3], k[7], k[4], k[9], k[8]};
    endfunction

    function automatic logic [0:1] sbox0(input logic [3:0] row_col);
        case (row_col)
            4'd0:  sbox0 = 2'd1;  4'd1:  sbox0 = 2'd0;
            4'd2:  sbox0 = 2'd3;  4'd3:  sbox0 = 2'd2;
            4'd4:  sbox0 = 2'd3;  4'd5:  sbox0 = 2'd2;
            4'd6:  sbox0 = 2'd1;  4'd7:  sbox0 = 2'd0;
            4'd8:  sbox0 = 2'd0;  4'd9:  sbox0 = 2'd2;
            4'd10: sbox0 = 2'd1;  4'd11: sbox0 = 2'd3;
            4'd12: sbox0 = 2'd3;  4'd13: sbox0 = 2'd1;
            4'd14: sbox0 = 2'd3;  4'd15: sbox0 = 2'd2;
            default: sbox0 = 2'd0;
        endcase
    endfunction

    function automatic logic [0:1] sbox1(input logic [3:0] row_col);
        case (row_col)
            4'd0:  sbox1 = 2'd0;  4'd1:  sbox1 = 2'd1;
            4'd2:  sbox1 = 2'd2;  4'd3:  sbox1 = 2'd3;
            4'd4:  sbox1 = 2'd2;  4'd5:  sbox1 = 2'd0;
            4'd6:  sbox1 = 2'd1;  4'd7:  sbox1 = 2'd3;
            4'd8:  sbox1 = 2'd3;  4'd9:  sbox1 = 2'd0;
            4'd10: sbox1 = 2'd1;  4'd11: sbox1 = 2'd0;
            4'd12: sbox1 = 2'd2;  4'd13: sbox1 = 2'd1;
            4'd14: sbox1 = 2'd0;  4'd15: sbox1 = 2'd3;
            default: sbox1 = 2'd0;
        endcase
    endfunction

    // Round function: expand/permute R, mix key, S-boxes, P4.
    // S-box address is {row = bits 1,4 ; column = bits 2,3} of each nibble.
    function automatic logic [0:3] round_f(input logic [0:3] r, input logic [0:7] k);
        logic [0:7] x;
        logic [0:1] s0;
        logic [0:1] s1;
        x  = {r[3], r[0], r[1], r[2], r[1], r[2], r[3], r[0]} ^ k;
        s0 = sbox0({x[0], x[3], x[1], x[2]});
        s1 = sbox1({x[4], x[7], x[5], x[6]});
        round_f = {s0[1], s1[1], s1[0], s0[0]};
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [0:KEY_W-1]    key_q,   key_d;
    logic [0:TEXT_W-1]   blk_q,   blk_d;
    logic [0:TEXT_W-1]   ka_q,    ka_d;
    logic [0:TEXT_W-1]   kb_q,    kb_d;
    logic [0:TEXT_W-1]   out_q,   out_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
`ifdef SDES_DECRYPT_EN
    logic                dec_q,   dec_d;
`endif

    // Subkeys from the latched key: K1 uses LS1 of each P10 half, K2 uses LS3.
    logic [0:KEY_W-1]    p10_s;
    logic [0:TEXT_W-1]   k1_s;
    logic [0:TEXT_W-1]   k2_s;

    assign p10_s = perm_p10(key_q);
    assign k1_s  = perm_p8({p10_s[1:4], p10_s[0], p10_s[6:9], p10_s[5]});
    assign k2_s  = perm_p8({p10_s[3:4], p10_s[0:2], p10_s[8:9], p10_s[5:7]});

    // Next-state and datapath decode for the block FSM.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        blk_d   = blk_q;
        ka_d    = ka_q;
        kb_d    = kb_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SDES_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PERM;
                    key_d   = keyIn;
                    blk_d   = inputText;
                    busy_d  = 1'b1;
`ifdef SDES_DECRYPT_EN
                    dec_d   = decrypt;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PERM: begin
                state_d = ST_RND1;
                blk_d   = perm_ip(blk_q);
`ifdef SDES_DECRYPT_EN
                if (dec_q) begin
                    ka_d = k2_s;
                    kb_d = k1_s;
                end else begin
                    ka_d = k1_s;
                    kb_d = k2_s;
                end
`else
                ka_d    = k1_s;
                kb_d    = k2_s;
`endif
            end
            ST_RND1: begin
                // First round ends with the half swap.
                state_d = ST_RND2;
                blk_d   = {blk_q[4:7], blk_q[0:3] ^ round_f(blk_q[4:7], ka_q)};
            end
            ST_RND2: begin
                state_d = ST_FIN;
                blk_d   = {blk_q[0:3] ^ round_f(blk_q[4:7], kb_q), blk_q[4:7]};
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                out_d   = perm_ip_inv(blk_q);
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any block in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= 10'd0;
            blk_q   <= 8'd0;
            ka_q    <= 8'd0;
            kb_q    <= 8'd0;
            out_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SDES_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            blk_q   <= blk_d;
            ka_q    <= ka_d;
            kb_q    <= kb_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SDES_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign outputText = out_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
